// File: rtl/rbot_motor_pkg.sv
// Shared motor-channel definitions for the cube-solver step scheduler.
// Holds face indices, the sequencing state type and direction encodings.
package rbot_motor_pkg;

    localparam int NUM_FACES = 6;
    localparam int FACE_W    = 3;

    localparam logic [FACE_W-1:0] FACE_U = 3'd0;
    localparam logic [FACE_W-1:0] FACE_D = 3'd1;
    localparam logic [FACE_W-1:0] FACE_F = 3'd2;
    localparam logic [FACE_W-1:0] FACE_B = 3'd3;
    localparam logic [FACE_W-1:0] FACE_L = 3'd4;
    localparam logic [FACE_W-1:0] FACE_R = 3'd5;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STEP_HI,
        STEP_LO,
        SETTLE,
        DONE
    } state_t;

    function automatic logic face_legal(input logic [FACE_W-1:0] f);
        return (f >= FACE_U) && (f <= FACE_R);
    endfunction

    function automatic logic [NUM_FACES-1:0] face_onehot(input logic [FACE_W-1:0] f);
        return NUM_FACES'(1) << f;
    endfunction

endpackage

// File: rtl/move_step_scheduler_if.sv
// Move-command handshake between the solution-sequence reader and the scheduler.
interface move_step_scheduler_if;
    import rbot_motor_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [FACE_W-1:0] cmd_face;
    logic              cmd_dir;
    logic              cmd_half;

    modport master (
        output cmd_valid,
        output cmd_face,
        output cmd_dir,
        output cmd_half,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_face,
        input  cmd_dir,
        input  cmd_half,
        output cmd_ready
    );

endinterface

// File: rtl/step_tick_gen.sv
// Free-running step-rate divider; restarts its period whenever clear is high.
module step_tick_gen #(
    parameter int STEP_DIV = 31249
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int              CW   = (STEP_DIV > 0) ? $clog2(STEP_DIV + 1) : 1;
    localparam logic [CW-1:0]   LAST = CW'(STEP_DIV);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/move_step_scheduler.sv
// Sequences one face turn at a time onto six stepper drivers: direction setup,
// step pulses at the tick rate, a torque-hold settle interval, then done.
module move_step_scheduler
    import rbot_motor_pkg::*;
#(
    parameter int STEP_DIV          = 31249,
    parameter int STEPS_PER_QUARTER = 50,
    parameter int SETTLE_TICKS      = 40
) (
    input  logic                  clock,
    input  logic                  reset,
    move_step_scheduler_if.slave  cmd,
    input  logic                  abort,
    output logic [NUM_FACES-1:0]  step_out,
    output logic [NUM_FACES-1:0]  dir_out,
    output logic [NUM_FACES-1:0]  en_out,
    output logic                  busy,
    output logic                  done,
    output logic                  cmd_error
);

    localparam int SCW = $clog2(2 * STEPS_PER_QUARTER + 1);
    localparam int STW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;

    localparam logic [SCW-1:0] QUARTER_STEPS = SCW'(STEPS_PER_QUARTER);
    localparam logic [SCW-1:0] HALF_STEPS    = SCW'(2 * STEPS_PER_QUARTER);
    localparam logic [STW-1:0] SETTLE_LAST   = STW'((SETTLE_TICKS > 0) ? SETTLE_TICKS - 1 : 0);

    state_t            state;
    logic              ready_q;
    logic [FACE_W-1:0] face_q;
    logic [SCW-1:0]    steps_left;
    logic [STW-1:0]    settle_cnt;
    logic              accept;
    logic              tick;

    assign cmd.cmd_ready = ready_q;
    assign accept        = cmd.cmd_valid && ready_q;

    step_tick_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .clear (accept),
        .tick  (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_error  <= 1'b0;
            step_out   <= '0;
            dir_out    <= '0;
            en_out     <= '0;
            face_q     <= '0;
            steps_left <= '0;
            settle_cnt <= '0;
        end else begin
            done      <= 1'b0;
            cmd_error <= 1'b0;
            // Abort only cancels a move in flight; in IDLE a pending command still wins.
            if (abort && (state != IDLE)) begin
                state    <= IDLE;
                ready_q  <= 1'b1;
                busy     <= 1'b0;
                step_out <= '0;
                dir_out  <= '0;
                en_out   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            if (face_legal(cmd.cmd_face)) begin
                                state      <= SETUP;
                                ready_q    <= 1'b0;
                                busy       <= 1'b1;
                                face_q     <= cmd.cmd_face;
                                en_out     <= face_onehot(cmd.cmd_face);
                                dir_out    <= (cmd.cmd_dir == DIR_CW) ? face_onehot(cmd.cmd_face) : '0;
                                steps_left <= cmd.cmd_half ? HALF_STEPS : QUARTER_STEPS;
                            end else begin
                                cmd_error <= 1'b1;
                            end
                        end else begin
                            ready_q <= 1'b1;
                        end
                    end
                    SETUP: begin
                        if (tick) begin
                            state    <= STEP_HI;
                            step_out <= face_onehot(face_q);
                        end
                    end
                    STEP_HI: begin
                        if (tick) begin
                            state    <= STEP_LO;
                            step_out <= '0;
                        end
                    end
                    STEP_LO: begin
                        if (tick) begin
                            steps_left <= steps_left - 1'b1;
                            if (steps_left > SCW'(1)) begin
                                state    <= STEP_HI;
                                step_out <= face_onehot(face_q);
                            end else begin
                                state      <= SETTLE;
                                settle_cnt <= '0;
                            end
                        end
                    end
                    SETTLE: begin
                        if (tick) begin
                            if (settle_cnt == SETTLE_LAST) begin
                                state   <= DONE;
                                done    <= 1'b1;
                                en_out  <= '0;
                                dir_out <= '0;
                            end else begin
                                settle_cnt <= settle_cnt + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/move_step_scheduler.md
Name: move_step_scheduler

Overview:
- Sequences one cube-face turn at a time onto six stepper motor drivers.
- Accepts move commands over a valid/ready handshake and generates step, direction and enable signals for the addressed face.
- Step timing comes from an internal rate tick derived from the 25 MHz system clock.
- Sits between the solution-sequence reader and the motor driver pins; holds torque through a settle interval, then reports done.

Parameters:
- STEP_DIV, 31249: tick period is STEP_DIV+1 clocks (31250 clocks = 1.25 ms at 25 MHz).
- STEPS_PER_QUARTER, 50: motor steps per 90-degree turn (200-step motor).
- SETTLE_TICKS, 40: ticks the enable is held after the last step.
- NUM_FACES, 6: number of motor channels.

Ports:
- clock  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle and able to accept.
- cmd_face  in  3  face index 0..5 (U,D,F,B,L,R); 6 and 7 are illegal.
- cmd_dir  in  1  1 = clockwise, 0 = counter-clockwise.
- cmd_half  in  1  1 = 180-degree turn, 0 = 90-degree turn.
- abort  in  1  synchronous abort of the move in progress.
- step_out  out  NUM_FACES  one-hot step pulse to the active face.
- dir_out  out  NUM_FACES  direction level; only the active face's bit is driven, others are 0.
- en_out  out  NUM_FACES  one-hot driver enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-clock pulse when a move completes normally.
- cmd_error  out  1  one-clock pulse when an illegal face is accepted.

Behaviour:
- Reset (reset=0, async): state=IDLE, tick counter=0, step counter=0. All outputs 0 except cmd_ready=1 once reset deasserts.
- Handshake: accept occurs on the edge where cmd_valid=1 and cmd_ready=1. cmd_ready=1 only in IDLE. Command fields are latched at accept; later input changes are ignored.
- Tick generator:
  - Counter is cleared on accept.
  - Asserts tick for one clock when count==STEP_DIV, then wraps to 0.
  - Counter width is clog2(STEP_DIV+1).
- FSM states: IDLE, SETUP, STEP_HI, STEP_LO, SETTLE, DONE.
  - IDLE -> SETUP on accept of a legal face. On an illegal face: pulse cmd_error the next cycle, stay ready, no motor output.
  - SETUP: en_out and dir_out set for the latched face. Hold 1 tick (direction setup time). Then go to STEP_HI.
  - STEP_HI: step_out bit high for 1 tick. Then go to STEP_LO.
  - STEP_LO: step_out low for 1 tick. Decrement remaining count. Go to STEP_HI if remaining>0, else SETTLE.
  - SETTLE: enable held, SETTLE_TICKS ticks. Then go to DONE.
  - DONE: done=1 for one clock, outputs cleared. Go to IDLE.
- Step count: STEPS_PER_QUARTER, or 2*STEPS_PER_QUARTER when cmd_half=1. Counter width is clog2(2*STEPS_PER_QUARTER+1).
- Latency from the accept edge to done: (1 + 2*steps + SETTLE_TICKS)*(STEP_DIV+1) clocks.
- abort in any non-IDLE state:
  - Next edge: step_out/en_out/dir_out all 0, state=IDLE.
  - No done pulse.
  - abort in IDLE has no effect.
  - If abort and cmd_valid are high in the same cycle in IDLE, the command is accepted (abort is ignored).
- Reset mid-move: outputs drop asynchronously; no done pulse.
- step_out is registered and glitch-free; at most one bit of step_out or en_out is ever high.

Decomposition:
- Shared package rbot_motor_pkg:
  - face index constants FACE_U..FACE_R and NUM_FACES;
  - state enum typedef;
  - DIR_CW/DIR_CCW constants.
- Sub-module step_tick_gen:
  - inputs clock, reset, clear;
  - parameter STEP_DIV;
  - output tick.

Test Plan (STEP_DIV=3, STEPS_PER_QUARTER=2, SETTLE_TICKS=2 unless stated):
- Quarter turn, face=2, dir=1 -> en_out=6'b000100 and dir_out=6'b000100 from the edge after accept; exactly 2 step pulses, each 4 clocks high and 4 low; done exactly 28 clocks after accept; cmd_ready=1 the next clock.
- Half turn, face=5, dir=0 -> 4 step pulses on bit 5, dir_out=0 throughout; done 44 clocks after accept.
- Illegal face=7 -> cmd_error pulses 1 clock; no step/en activity; cmd_ready=1 on the following clock; no done.
- abort asserted during the second STEP_HI of a quarter turn -> all motor outputs 0 on the next edge, busy=0, no done; a new command accepted immediately after completes normally in 28 clocks.
- Back-to-back: cmd_valid held high with two commands -> second accepted on the clock after done; cmd_valid during busy is not accepted (cmd_ready=0).
- reset pulsed low mid-SETTLE -> outputs 0 asynchronously; after release cmd_ready=1 and the tick counter restarts from 0 on the next accept.
